// File: rtl/ram_dualport.sv
// True dual-port RAM, registered read-first outputs, optional fill.
// Port A: accumulator read/write addresses; port B: access port.
module ram_dualport #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE = 2**ADDR_WIDTH,
  parameter int FILLMEM = 1,
  parameter logic [DATA_WIDTH-1:0] FILLMEM_DATA = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cke_i,
  input  logic                  a_ren_i,
  input  logic [ADDR_WIDTH-1:0] a_raddr_i,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_waddr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  input  logic                  b_en_i,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_din_i,
  output logic [DATA_WIDTH-1:0] b_dout_o
);

  localparam logic [DATA_WIDTH-1:0] FILL_INIT =
    (FILLMEM != 0) ? FILLMEM_DATA : '0;

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE] = '{default: FILL_INIT};
  logic [DATA_WIDTH-1:0] a_rdata_q;
  logic [DATA_WIDTH-1:0] b_dout_q;

  // Port A write is issued last so it wins an address collision.
  always_ff @(posedge clk_i) begin
    if (!rst_i && cke_i) begin
      if (b_en_i && b_we_i) mem_q[b_addr_i] <= b_din_i;
      if (a_we_i) mem_q[a_waddr_i] <= a_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cke_i && a_ren_i) a_rdata_q <= mem_q[a_raddr_i];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) b_dout_q <= '0;
    else if (cke_i && b_en_i) b_dout_q <= mem_q[b_addr_i];
  end

  assign a_rdata_o = a_rdata_q;
  assign b_dout_o  = b_dout_q;

endmodule

// File: rtl/ram_accumulator.sv
// RAM accumulator: 3-stage read-modify-write with result forwarding,
// an access port, and a running maximum tracker.
module ram_accumulator #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE = 2**ADDR_WIDTH,
  parameter int FILLMEM = 1,
  parameter logic [DATA_WIDTH-1:0] FILLMEM_DATA = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cke,
  input  logic [ADDR_WIDTH-1:0] acc_addr,
  input  logic [DATA_WIDTH-1:0] acc_data,
  input  logic                  acc_operation,
  input  logic                  acc_valid,
  input  logic                  mem_en,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_din,
  output logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  max_clear,
  output logic [ADDR_WIDTH-1:0] max_addr,
  output logic [DATA_WIDTH-1:0] max_data
);

  logic                  s1_vld_q, s2_vld_q, w3_vld_q;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s2_addr_q, w3_addr_q;
  logic [DATA_WIDTH-1:0] s1_data_q, s2_data_q, s2_base_q, w3_data_q;
  logic                  s1_op_q, s2_op_q;
  logic [ADDR_WIDTH-1:0] max_addr_q, max_addr_d;
  logic [DATA_WIDTH-1:0] max_data_q, max_data_d;
  logic [DATA_WIDTH-1:0] ram_rd, s1_base, s2_res;

  ram_dualport #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .MEM_SIZE    (MEM_SIZE),
    .FILLMEM     (FILLMEM),
    .FILLMEM_DATA(FILLMEM_DATA)
  ) u_ram (
    .clk_i    (clk),
    .rst_i    (reset),
    .cke_i    (cke),
    .a_ren_i  (acc_valid),
    .a_raddr_i(acc_addr),
    .a_rdata_o(ram_rd),
    .a_we_i   (s2_vld_q),
    .a_waddr_i(s2_addr_q),
    .a_wdata_i(s2_res),
    .b_en_i   (mem_en),
    .b_we_i   (mem_we),
    .b_addr_i (mem_addr),
    .b_din_i  (mem_din),
    .b_dout_o (mem_dout)
  );

  // RAM read misses the write in stage 2 and the one that committed
  // on the same edge as the read; newest matching result wins.
  always_comb begin
    s2_res = s2_op_q ? s2_base_q - s2_data_q
                     : s2_base_q + s2_data_q;
    s1_base = ram_rd;
    if (s2_vld_q && s2_addr_q == s1_addr_q) s1_base = s2_res;
    else if (w3_vld_q && w3_addr_q == s1_addr_q) s1_base = w3_data_q;
    max_addr_d = max_addr_q;
    max_data_d = max_data_q;
    if (max_clear) begin
      max_addr_d = '0;
      max_data_d = '0;
    end else if (s2_vld_q && s2_res > max_data_q) begin
      max_addr_d = s2_addr_q;
      max_data_d = s2_res;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      w3_vld_q   <= 1'b0;
      max_addr_q <= '0;
      max_data_q <= '0;
    end else if (cke) begin
      s1_vld_q   <= acc_valid;
      s1_addr_q  <= acc_addr;
      s1_data_q  <= acc_data;
      s1_op_q    <= acc_operation;
      s2_vld_q   <= s1_vld_q;
      s2_addr_q  <= s1_addr_q;
      s2_data_q  <= s1_data_q;
      s2_op_q    <= s1_op_q;
      s2_base_q  <= s1_base;
      w3_vld_q   <= s2_vld_q;
      w3_addr_q  <= s2_addr_q;
      w3_data_q  <= s2_res;
      max_addr_q <= max_addr_d;
      max_data_q <= max_data_d;
    end
  end

  assign max_addr = max_addr_q;
  assign max_data = max_data_q;

endmodule

// File: tb/tb_ram_accumulator.sv
// Scoreboard bench for ram_accumulator: random and directed
// accumulate traffic against an array-based reference model.
module tb_ram_accumulator;
  localparam int AW = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, cke;
  logic [AW-1:0] acc_addr, mem_addr, max_addr;
  logic [DW-1:0] acc_data, mem_din, mem_dout, max_data;
  logic          acc_operation, acc_valid;
  logic          mem_en, mem_we, max_clear;

  always #5 clk = ~clk;

  ram_accumulator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .cke(cke),
    .acc_addr(acc_addr), .acc_data(acc_data),
    .acc_operation(acc_operation), .acc_valid(acc_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .max_clear(max_clear), .max_addr(max_addr), .max_data(max_data)
  );

  int n_tests = 0;
  int n_fail = 0;

  logic [DW-1:0] model [8];
  logic [DW-1:0] mmax;
  logic [AW-1:0] maddr;
  logic [DW-1:0] exp_q [$];
  bit            ovr, skip_pw;
  logic [DW-1:0] ovr_val;
  bit            fired;

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_max(string name);
    check({name, "_addr"}, DW'(max_addr), DW'(maddr));
    check({name, "_data"}, max_data, mmax);
  endtask

  // Model applies each accepted cycle in program order.
  task automatic tick();
    logic [DW-1:0] r;
    if (reset) begin
      mmax = '0;
      maddr = '0;
    end else if (cke) begin
      if (mem_en) exp_q.push_back(ovr ? ovr_val : model[mem_addr]);
      if (mem_en && mem_we && !skip_pw) model[mem_addr] = mem_din;
      if (acc_valid) begin
        r = acc_operation ? model[acc_addr] - acc_data
                          : model[acc_addr] + acc_data;
        model[acc_addr] = r;
        if (r > mmax) begin
          mmax = r;
          maddr = acc_addr;
        end
      end
      if (max_clear) begin
        mmax = '0;
        maddr = '0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; cke = 1; acc_valid = 0; acc_operation = 1'bx;
    acc_addr = 'x; acc_data = 'x; mem_en = 0; mem_we = 0;
    mem_addr = '0; mem_din = '0; max_clear = 0;
    ovr = 0; skip_pw = 0;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic acc(int a, logic [DW-1:0] d, logic op);
    acc_valid = 1; acc_addr = a[AW-1:0];
    acc_data = d; acc_operation = op;
    tick();
    idle();
  endtask

  task automatic rd(int a);
    mem_en = 1; mem_we = 0; mem_addr = a[AW-1:0];
    tick();
    idle();
  endtask

  task automatic sweep();
    drain();
    for (int a = 0; a < 8; a++) rd(a);
    drain();
  endtask

  always @(posedge clk) fired = !reset && cke && mem_en;

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (fired) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_underflow: got %h expected none", mem_dout);
      end else begin
        e = exp_q.pop_front();
        check("mem_dout", mem_dout, e);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] save;
    for (int i = 0; i < 8; i++) model[i] = '0;
    mmax = '0; maddr = '0;
    idle();
    reset = 1;
    tick(); tick();
    idle();
    check("rst_dout", mem_dout, '0);
    chk_max("rst_max");

    repeat (3) begin
      acc_valid = 1; acc_addr = 3'd2; acc_data = 5; acc_operation = 0;
      tick();
    end
    drain();
    rd(2);
    drain();
    chk_max("add5x3");

    acc(1, 32'hFF, 0);
    acc(1, 32'h0F, 1);
    acc(1, 32'h01, 0);
    drain();
    rd(1);
    drain();
    chk_max("alt_addr1");

    acc(7, 32'h1, 1);
    drain();
    rd(7);
    drain();
    chk_max("wrap7");

    max_clear = 1;
    tick();
    idle();
    tick();
    chk_max("clear");
    acc(4, 32'h3, 0);
    drain();
    chk_max("after_clear");

    for (int i = 0; i < 200; i++) begin
      acc_valid = 1'($urandom_range(0, 1));
      acc_addr = AW'($urandom_range(0, 7));
      acc_data = DW'($urandom_range(0, 255));
      acc_operation = 0;
      tick();
    end
    sweep();
    chk_max("rand_add");

    max_clear = 1;
    tick();
    idle();
    for (int i = 0; i < 80; i++) begin
      cke = !(i >= 30 && i < 35);
      acc_valid = 1'($urandom_range(0, 3) != 0);
      acc_addr = AW'($urandom_range(0, 7));
      acc_data = $urandom;
      acc_operation = 1'($urandom_range(0, 1));
      max_clear = !cke;
      tick();
    end
    sweep();
    chk_max("rand_stall");

    rd(0);
    cke = 0; mem_en = 1; mem_addr = 3'd3;
    acc_valid = 1; acc_addr = 3'd0; acc_data = 32'h55; acc_operation = 0;
    max_clear = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cke_hold_dout", mem_dout, model[0]);
    end
    drain();
    chk_max("cke_hold_max");
    sweep();

    rd(6);
    save = model[3];
    acc(3, 32'h100, 0);
    reset = 1;
    tick();
    idle();
    model[3] = save;
    check("rst2_dout", mem_dout, '0);
    chk_max("rst2_max");
    drain();
    rd(3);
    drain();

    mem_en = 1; mem_we = 1; mem_addr = 3'd6; mem_din = 32'hDEADBEEF;
    tick();
    idle();
    rd(6);
    drain();

    save = model[5];
    acc(5, 32'h10, 0);
    tick();
    mem_en = 1; mem_we = 1; mem_addr = 3'd5; mem_din = 32'h1234;
    skip_pw = 1; ovr = 1; ovr_val = save;
    tick();
    idle();
    drain();
    rd(5);
    sweep();
    chk_max("final");

    check("rd_pending", DW'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_accumulator.md
RAM_ACCUMULATOR -- requirements
Module: ram_accumulator

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_WIDTH, 3, address bits.
- DATA_WIDTH, 32, word width.
- MEM_SIZE, 2**ADDR_WIDTH, number of words.
- FILLMEM, 1, nonzero means the RAM is initialised at configuration time.
- FILLMEM_DATA, 0, initial value of every word.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- reset, in, 1, synchronous, active-high.
- cke, in, 1, clock enable; all state holds while low.
- acc_addr, in, ADDR_WIDTH, accumulate address.
- acc_data, in, DATA_WIDTH, operand.
- acc_operation, in, 1, 0 = add, 1 = subtract.
- acc_valid, in, 1, request strobe.
- mem_en, in, 1, access port enable.
- mem_we, in, 1, access port write enable.
- mem_addr, in, ADDR_WIDTH, access port address.
- mem_din, in, DATA_WIDTH, access port write data.
- mem_dout, out, DATA_WIDTH, access port read data.
- max_clear, in, 1, clear the maximum tracker.
- max_addr, out, ADDR_WIDTH, address of the largest accumulated value.
- max_data, out, DATA_WIDTH, largest accumulated value.

Function
REQ-003 Every cycle with cke=1 and acc_valid=1 accepts one request; no backpressure; acc_addr/acc_data/acc_operation are ignored (may be X) when acc_valid=0.
REQ-004 Each accepted request performs mem[acc_addr] = mem[acc_addr] + acc_data (op 0) or - acc_data (op 1), modulo 2**DATA_WIDTH.
REQ-005 Read-modify-write pipeline: RAM read in the acceptance cycle, read data at +1, compute and write at +2; the write commits by the end of cycle +2.
REQ-006 Result forwarding SHALL make any request sequence, including back-to-back and alternating same-address requests, equal sequential in-order execution.
REQ-007 Access port: when mem_en=1 it reads mem[mem_addr] and registers it to mem_dout at the next edge (read latency 1); mem_dout holds when mem_en=0.
REQ-008 Access port write: when mem_en=1 and mem_we=1 it writes mem_din. A same-cycle, same-address write from the accumulator wins. Accumulator requests in flight are not forwarded from access port writes.
REQ-009 Access port read of an address being written in the same cycle returns the old value (read-first).
REQ-010 Maximum tracker, evaluated on each accumulator write: if the result > max_data (unsigned), max_data and max_addr are updated to it on the next edge; ties keep the older entry.
REQ-011 max_clear=1 sets max_addr=0 and max_data=0; it overrides a same-cycle update.
REQ-012 cke=0 freezes pipeline registers, RAM writes, mem_dout and the max tracker.
REQ-013 RAM contents are FILLMEM_DATA at start when FILLMEM≠0; otherwise they are undefined.

Reset
REQ-014 Synchronous reset clears pipeline valids (in-flight requests are discarded and not written), max_addr=0, max_data=0 and mem_dout=0.
REQ-015 Reset does not modify RAM contents; reset takes precedence over cke.

Structure
REQ-016 No shared package; all widths are module parameters.
REQ-017 One sub-module, ram_dualport: true dual-port, registered read, read-first, optional fill. Port A is the accumulator (read address and write address); port B is the access port.

Verification
REQ-018 After reset, add 5 to addr 2 for 3 consecutive cycles, then read addr 2 via the access port -> mem_dout=15, max_addr=2, max_data=15.
REQ-019 Alternate requests to addr 1 and addr 1: add 0xFF, subtract 0x0F, add 0x01 -> mem[1]=0xF1.
REQ-020 Subtract 1 from addr 7 (value 0) -> mem[7]=0xFFFFFFFF and max_data=0xFFFFFFFF.
REQ-021 Random 8-bit adds to random addresses with random valid for 200 cycles -> an access-port read sweep of addresses 0..7 equals the software model; max_data equals the largest model value.
REQ-022 Assert max_clear -> next cycle max_addr=0, max_data=0; then add 3 to addr 4 -> max_addr=4, max_data=3.
REQ-023 Hold cke=0 for 5 cycles mid-stream with acc_valid=1 -> RAM and max outputs unchanged; results identical to the same run without the stall.
